ifa_mem_responder: RTL



---
 rtl/ifa_pkg.sv | 21 ++
 rtl/ifa_mem_array.sv | 22 ++
 rtl/ifa_mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/ifa_pkg.sv
// Shared types for the ifa memory responder: command encodings, FSM states
// and the wait-state counter width.
package ifa_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MODE_NOP  = 2'b00,
    MODE_RD   = 2'b01,
    MODE_WR   = 2'b10,
    MODE_SWAP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/ifa_mem_array.sv
// Storage behind the responder: combinational read port and a synchronous
// write port sharing one address. Contents are deliberately not reset.
module ifa_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ifa_mem_responder.sv
// Memory-side responder for the ifa req/gnt bus: grants one initiator, latches
// a command on start and completes it after WAIT_CYCLES extra wait states.
module ifa_mem_responder
  import ifa_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  mode_e             mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              access_now;
  logic              mem_we;

  // Writes are gated by rst so a reset landing on the access edge aborts the store.
  always_comb begin
    access_now = (state == ACCESS) && (cnt == '0);
    mem_we     = access_now && !rst && (mode_q == MODE_WR || mode_q == MODE_SWAP);
  end

  ifa_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= 1'b0;
      rdy     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      mode_q  <= MODE_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state <= GRANT;
            gnt   <= 1'b1;
          end
        end
        GRANT: begin
          if (start) begin
            mode_q  <= mode_e'(mode);
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (mode_e'(mode) == MODE_NOP) begin
              state <= DONE;
              rdy   <= 1'b1;
              rdata <= '0;
            end else begin
              state <= ACCESS;
              cnt   <= WAIT_INIT;
            end
          end else if (!req) begin
            state <= IDLE;
            gnt   <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
            rdy   <= 1'b1;
            // SWAP captures the pre-write value because the read port is combinational.
            rdata <= (mode_q == MODE_RD || mode_q == MODE_SWAP) ? mem_rdata : '0;
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (req) begin
            state <= GRANT;
          end else begin
            state <= IDLE;
            gnt   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
